// File: rtl/gcm_len_counter.sv
// gcm_len_counter: per-message AAD/CT byte counter feeding the GCM length-block builder.
// Optional feature macro: GCM_LEN_LIMIT_CHECK_EN (adds SP 800-38D total-length comparators).
module gcm_len_counter #(
  parameter int unsigned BEAT_BYTES = 16,
  parameter int unsigned CNT_W      = 61
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              aad_valid,
  input  logic                              ct_valid,
  input  logic [$clog2(BEAT_BYTES):0]       beat_bytes,
  output logic                              beat_ready,
  input  logic                              finish,
  output logic [63:0]                       len_aad_bits,
  output logic [63:0]                       len_ct_bits,
  output logic                              len_valid,
  output logic                              err,
  output logic                              busy
);

  localparam int unsigned BB_W  = $clog2(BEAT_BYTES) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned LEN_W = 64;

`ifdef GCM_LEN_LIMIT_CHECK_EN
  // Largest legal totals: CT 2^36-32 bytes, AAD 2^61-1 bytes.
  localparam logic [SUM_W-1:0] CT_LIM  = SUM_W'(64'h0000_000F_FFFF_FFE0);
  localparam logic [SUM_W-1:0] AAD_LIM = SUM_W'(64'h1FFF_FFFF_FFFF_FFFF);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AAD  = 2'd1,
    S_CT   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   aad_cnt, aad_cnt_d;
  logic [CNT_W-1:0]   ct_cnt, ct_cnt_d;
  logic               aad_part, aad_part_d;
  logic               ct_part, ct_part_d;
  logic               err_d;

  logic               active;
  logic               bytes_bad;
  logic               partial;
  logic [SUM_W-1:0]   sum;
  logic               sat;
  logic [CNT_W-1:0]   cnt_new;

  // Beat acceptance and state decodes.
  always_comb begin
    active     = (state == S_AAD) || (state == S_CT);
    beat_ready = active && !start && !finish;
    busy       = active;
    len_valid  = (state == S_DONE);
  end

  // Candidate count for the offered beat, with saturation at the counter maximum.
  always_comb begin
    bytes_bad = (beat_bytes == '0) || (beat_bytes > BB_W'(BEAT_BYTES));
    partial   = (beat_bytes < BB_W'(BEAT_BYTES));
    sum       = {1'b0, (ct_valid ? ct_cnt : aad_cnt)} + SUM_W'(beat_bytes);
    sat       = sum[CNT_W];
    cnt_new   = sat ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

  // Next state, counters, phase-closing flags and sticky error.
  always_comb begin
    state_d    = state;
    aad_cnt_d  = aad_cnt;
    ct_cnt_d   = ct_cnt;
    aad_part_d = aad_part;
    ct_part_d  = ct_part;
    err_d      = err;

    if (start) begin
      state_d    = S_AAD;
      aad_cnt_d  = '0;
      ct_cnt_d   = '0;
      aad_part_d = 1'b0;
      ct_part_d  = 1'b0;
      err_d      = 1'b0;
    end else if (active && finish) begin
      state_d = S_DONE;
    end else if (beat_ready && (aad_valid || ct_valid)) begin
      if (aad_valid && ct_valid) begin
        err_d = 1'b1;
      end else if (bytes_bad) begin
        err_d = 1'b1;
      end else if (aad_valid) begin
        // AAD after CT started, or after a partial AAD beat, is rejected.
        if ((state == S_CT) || aad_part) begin
          err_d = 1'b1;
        end else begin
          aad_cnt_d = cnt_new;
          if (partial) aad_part_d = 1'b1;
          if (sat) err_d = 1'b1;
`ifdef GCM_LEN_LIMIT_CHECK_EN
          if (sum > AAD_LIM) err_d = 1'b1;
`endif
        end
      end else begin
        // Only a counted CT beat moves the message into the CT phase.
        if (ct_part) begin
          err_d = 1'b1;
        end else begin
          ct_cnt_d = cnt_new;
          state_d  = S_CT;
          if (partial) ct_part_d = 1'b1;
          if (sat) err_d = 1'b1;
`ifdef GCM_LEN_LIMIT_CHECK_EN
          if (sum > CT_LIM) err_d = 1'b1;
`endif
        end
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      aad_cnt  <= '0;
      ct_cnt   <= '0;
      aad_part <= 1'b0;
      ct_part  <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_d;
      aad_cnt  <= aad_cnt_d;
      ct_cnt   <= ct_cnt_d;
      aad_part <= aad_part_d;
      ct_part  <= ct_part_d;
      err      <= err_d;
    end
  end

  // Bit counts are the registered byte counts scaled by 8.
  always_comb begin
    len_aad_bits = LEN_W'({aad_cnt, 3'b000});
    len_ct_bits  = LEN_W'({ct_cnt, 3'b000});
  end

endmodule

// File: tb/tb_gcm_len_counter.sv
// tb_gcm_len_counter: directed stimulus with a queued-expectation scoreboard.
module tb_gcm_len_counter;

  logic        clk;
  logic        rst;
  logic        start;
  logic        aad_valid;
  logic        ct_valid;
  logic [4:0]  beat_bytes;
  logic        beat_ready;
  logic        finish;
  logic [63:0] len_aad_bits;
  logic [63:0] len_ct_bits;
  logic        len_valid;
  logic        err;
  logic        busy;

  gcm_len_counter dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .aad_valid    (aad_valid),
    .ct_valid     (ct_valid),
    .beat_bytes   (beat_bytes),
    .beat_ready   (beat_ready),
    .finish       (finish),
    .len_aad_bits (len_aad_bits),
    .len_ct_bits  (len_ct_bits),
    .len_valid    (len_valid),
    .err          (err),
    .busy         (busy)
  );

  typedef struct {
    string       name;
    logic [63:0] aad;
    logic [63:0] ct;
    logic        lv;
    logic        er;
    logic        bz;
    logic        rd;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

`ifdef GCM_LEN_LIMIT_CHECK_EN
  localparam logic LIM_ERR = 1'b1;
`else
  localparam logic LIM_ERR = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare the oldest expectation against the outputs presented at this falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      if (len_aad_bits === e.aad && len_ct_bits === e.ct && len_valid === e.lv &&
          err === e.er && busy === e.bz && beat_ready === e.rd) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got aad=%0h ct=%0h lv=%b err=%b busy=%b rdy=%b, want aad=%0h ct=%0h lv=%b err=%b busy=%b rdy=%b",
                 e.name, len_aad_bits, len_ct_bits, len_valid, err, busy, beat_ready,
                 e.aad, e.ct, e.lv, e.er, e.bz, e.rd);
      end
    end
  end

  // Drive one cycle of inputs, then return all inputs to idle just after the edge.
  task automatic cyc(input logic st, input logic fin, input logic av, input logic cv,
                     input logic [4:0] bb);
    start = st; finish = fin; aad_valid = av; ct_valid = cv; beat_bytes = bb;
    @(posedge clk);
    #1;
    start = 1'b0; finish = 1'b0; aad_valid = 1'b0; ct_valid = 1'b0; beat_bytes = 5'd0;
  endtask

  // Queue an expectation for the next falling edge and step past it.
  task automatic chk(input string nm, input logic [63:0] aad, input logic [63:0] ct,
                     input logic lv, input logic er, input logic bz, input logic rd);
    exp_t e;
    e.name = nm; e.aad = aad; e.ct = ct; e.lv = lv; e.er = er; e.bz = bz; e.rd = rd;
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; finish = 1'b0; aad_valid = 1'b0; ct_valid = 1'b0;
    beat_bytes = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Normal message: AAD 16+4, CT 16+16+7.
    cyc(1, 0, 0, 0, 5'd0);
    chk("t1_start", 64'd0, 64'd0, 0, 0, 1, 1);
    cyc(0, 0, 1, 0, 5'd16);
    cyc(0, 0, 1, 0, 5'd4);
    chk("t1_aad", 64'd160, 64'd0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 5'd16);
    cyc(0, 0, 0, 1, 5'd16);
    cyc(0, 0, 0, 1, 5'd7);
    chk("t1_ct", 64'd160, 64'd312, 0, 0, 1, 1);
    cyc(0, 1, 0, 0, 5'd0);
    chk("t1_done", 64'd160, 64'd312, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 5'd0);
    chk("t1_hold", 64'd160, 64'd312, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 5'd16);
    chk("done_ignore", 64'd160, 64'd312, 1, 0, 0, 0);

    // Empty message.
    cyc(1, 0, 0, 0, 5'd0);
    cyc(0, 1, 0, 0, 5'd0);
    chk("t2_empty", 64'd0, 64'd0, 1, 0, 0, 0);

    // AAD after CT is an ordering error.
    cyc(1, 0, 0, 0, 5'd0);
    cyc(0, 0, 0, 1, 5'd16);
    cyc(0, 0, 1, 0, 5'd16);
    chk("t3_order", 64'd0, 64'd128, 0, 1, 1, 1);

    // AAD after a partial AAD beat, then start clears everything.
    cyc(1, 0, 0, 0, 5'd0);
    cyc(0, 0, 1, 0, 5'd5);
    cyc(0, 0, 1, 0, 5'd16);
    chk("t4_aad_part", 64'd40, 64'd0, 0, 1, 1, 1);
    cyc(1, 0, 0, 0, 5'd0);
    chk("t4_clear", 64'd0, 64'd0, 0, 0, 1, 1);

    // start wins over a beat; oversize beat errors; error does not block legal beats.
    cyc(1, 0, 1, 0, 5'd16);
    chk("t5_start_beat", 64'd0, 64'd0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 5'd17);
    chk("t5_bad17", 64'd0, 64'd0, 0, 1, 1, 1);
    cyc(0, 0, 0, 1, 5'd16);
    chk("t5_after_err", 64'd0, 64'd128, 0, 1, 1, 1);

    // finish wins over a beat.
    cyc(1, 0, 0, 0, 5'd0);
    cyc(0, 0, 1, 0, 5'd16);
    cyc(0, 1, 1, 0, 5'd16);
    chk("fin_beat", 64'd128, 64'd0, 1, 0, 0, 0);

    // Both valids together.
    cyc(1, 0, 0, 0, 5'd0);
    cyc(0, 0, 1, 1, 5'd16);
    chk("both_valid", 64'd0, 64'd0, 0, 1, 1, 1);

    // Zero-byte beat.
    cyc(1, 0, 0, 0, 5'd0);
    cyc(0, 0, 1, 0, 5'd0);
    chk("zero_bytes", 64'd0, 64'd0, 0, 1, 1, 1);

    // CT after a partial CT beat.
    cyc(1, 0, 0, 0, 5'd0);
    cyc(0, 0, 0, 1, 5'd3);
    cyc(0, 0, 0, 1, 5'd16);
    chk("ct_part", 64'd0, 64'd24, 0, 1, 1, 1);

    // AAD counter saturation at 2^61-1 bytes.
    cyc(1, 0, 0, 0, 5'd0);
    force dut.aad_cnt = 61'h1FFF_FFFF_FFFF_FFFD;
    #1;
    release dut.aad_cnt;
    cyc(0, 0, 1, 0, 5'd16);
    chk("aad_sat", 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 0, 1, 1, 1);

    // CT one byte past 2^36-32.
    cyc(1, 0, 0, 0, 5'd0);
    force dut.ct_cnt = 61'h0_000F_FFFF_FFE0;
    #1;
    release dut.ct_cnt;
    cyc(0, 0, 0, 1, 5'd1);
    chk("t6_ct_limit", 64'd0, 64'h0000_007F_FFFF_FF08, 0, LIM_ERR, 1, 1);

    // Reset mid-message.
    cyc(1, 0, 0, 0, 5'd0);
    cyc(0, 0, 1, 0, 5'd16);
    rst = 1'b1;
    chk("rst_mid", 64'd0, 64'd0, 0, 0, 0, 0);
    rst = 1'b0;

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
      n_checks += q.size();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
